// File: rtl/sipo_frame_pkg.sv
// -----------------------------------------------------------------------------
// sipo_frame_pkg
//
// Shared definitions for the framed serial receive controller:
//   - state_t       : controller state encoding (2 bits; 2'd3 is unused and
//                     recovers to IDLE)
//   - DEFAULT_WIDTH : default number of data bits per frame
//   - is_stop_good  : names the polarity of a good stop bit
// -----------------------------------------------------------------------------
package sipo_frame_pkg;

  // Default data bits per frame; legal range for WIDTH is 2..32.
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_STOP = 2'd2
  } state_t;

  // The serial line idles high, so a valid stop bit is a 1.
  function automatic logic is_stop_good(input logic stop_bit);
    return stop_bit == 1'b1;
  endfunction

endpackage

// File: rtl/sipo_shift_reg.sv
// -----------------------------------------------------------------------------
// sipo_shift_reg
//
// WIDTH-bit serial-in / parallel-out shift register. Shifts left with din
// entering bit 0 on every rising edge where shift_en is high, so the first bit
// shifted in ends up in the MSB after WIDTH shifts.
//
// Ports:
//   clk      in   system clock (rising edge)
//   reset    in   synchronous, active-low reset; clears q
//   shift_en in   shift on this edge
//   din      in   serial bit shifted into bit 0
//   q        out  parallel contents
// -----------------------------------------------------------------------------
module sipo_shift_reg
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q <= '0;
    end else if (shift_en) begin
      q <= {q[WIDTH-2:0], din};
    end
  end

endmodule

// File: rtl/sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// sipo_frame_ctrl
//
// Framed serial receive controller. Detects a start bit (din==0 while idle),
// shifts exactly WIDTH data bits into a SIPO register, checks the stop bit and
// hands the word to a consumer through a one-deep output buffer.
//
// Frame on din: start(0), WIDTH data bits (first bit -> MSB), stop(1).
// Frame length is WIDTH+2 cycles; frames may run back to back.
//
// Ports:
//   clk         in   system clock (rising edge)
//   reset       in   synchronous, active-low reset
//   din         in   serial line, idles high
//   data_ready  in   consumer ready
//   data_out    out  last good word (registered)
//   data_valid  out  data_out holds an unconsumed word (registered)
//   busy        out  frame in progress, i.e. state != IDLE (registered)
//   frame_err   out  one-cycle pulse: stop bit sampled as 0
//   overrun     out  one-cycle pulse: good word dropped, buffer still full
//   dbg_state   out  current FSM state encoding, for observation only
//
// Handshake: a word transfers on every rising edge where data_valid and
// data_ready are both high. data_out is held stable while data_valid is high
// and data_ready is low. A transfer and a new load may coincide; the buffer
// then stays valid with the new word. data_ready only feeds registers, so it
// has no combinational path to any output.
// -----------------------------------------------------------------------------
module sipo_frame_ctrl
  import sipo_frame_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             busy,
  output logic             frame_err,
  output logic             overrun,
  output logic [1:0]       dbg_state
);

  // Counter spans 0..WIDTH inclusive.
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] shift_q;
  logic             shift_en;
  logic             last_bit;
  logic             can_load;

  // Shifting happens on every edge spent in DATA; the start bit is sampled in
  // IDLE and therefore never enters the register.
  assign shift_en  = (state == ST_DATA);

  // The edge that performs the WIDTH-th shift sees bit_cnt == WIDTH-1.
  assign last_bit  = (bit_cnt == CW'(WIDTH - 1));

  // The buffer can take a new word if it is empty or is draining this edge.
  assign can_load  = !data_valid || data_ready;

  assign dbg_state = state;

  sipo_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk      (clk),
    .reset    (reset),
    .shift_en (shift_en),
    .din      (din),
    .q        (shift_q)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses.
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // Consumer drains the buffer; a load in STOP below overrides this.
      if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (!din) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            busy    <= 1'b1;
          end
        end

        ST_DATA: begin
          bit_cnt <= bit_cnt + CW'(1);
          if (last_bit) begin
            state <= ST_STOP;
          end
        end

        ST_STOP: begin
          // Always back to IDLE, so a start bit right after the stop bit is
          // seen on the very next edge.
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (is_stop_good(din)) begin
            if (can_load) begin
              data_out   <= shift_q;
              data_valid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            frame_err <= 1'b1;
          end
        end

        default: begin
          // Unused encoding: recover quietly to IDLE.
          state   <= ST_IDLE;
          bit_cnt <= '0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sipo_frame_ctrl
//
// Directed scenarios followed by randomized traffic. A frame-level reference
// model (bit queue per frame + one-deep buffer) predicts every output after
// each clock edge.
// -----------------------------------------------------------------------------
module tb_sipo_frame_ctrl;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic         din;
  logic         data_ready;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         frame_err;
  logic         overrun;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  sipo_frame_ctrl #(
    .WIDTH (W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // ---------------- reference model ----------------
  logic         in_frame = 1'b0;
  logic         bits_q[$];
  logic [W-1:0] m_word   = '0;
  logic         m_valid  = 1'b0;
  logic         m_busy   = 1'b0;
  logic         m_err    = 1'b0;
  logic         m_ovr    = 1'b0;
  logic [W-1:0] exp_q[$];   // words the consumer should receive, in order

  function automatic logic [W-1:0] pack_bits();
    logic [W-1:0] w;
    w = '0;
    foreach (bits_q[k]) w = {w[W-2:0], bits_q[k]};
    return w;
  endfunction

  task automatic model_edge(input logic d, input logic r, input logic rst);
    logic consume;
    logic load;
    if (!rst) begin
      in_frame = 1'b0;
      bits_q.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_err   = 1'b0;
      m_ovr   = 1'b0;
      return;
    end
    m_err   = 1'b0;
    m_ovr   = 1'b0;
    consume = m_valid && r;
    load    = 1'b0;
    if (!in_frame) begin
      if (d == 1'b0) begin
        in_frame = 1'b1;
        bits_q.delete();
      end
    end else if (bits_q.size() < W) begin
      bits_q.push_back(d);
    end else begin
      in_frame = 1'b0;
      if (d) begin
        if (!m_valid || r) begin
          load   = 1'b1;
          m_word = pack_bits();
        end else begin
          m_ovr = 1'b1;
        end
      end else begin
        m_err = 1'b1;
      end
    end
    if (load) m_valid = 1'b1;
    else if (consume) m_valid = 1'b0;
    m_busy = in_frame;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_model();
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("busy",       32'(busy),       32'(m_busy));
    check("frame_err",  32'(frame_err),  32'(m_err));
    check("overrun",    32'(overrun),    32'(m_ovr));
    if (m_valid) check("data_out", 32'(data_out), 32'(m_word));
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the edge; outputs are sampled there too.
  task automatic cycle(input logic d, input logic r, input logic rst);
    din        = d;
    data_ready = r;
    reset      = rst;
    @(posedge clk);
    model_edge(d, r, rst);
    cyc++;
    #1;
    check_model();
  endtask

  // start + W data bits (MSB first) + stop; r_data applies to the start and
  // data cycles, r_stop to the stop cycle.
  task automatic send_frame(input logic [W-1:0] w, input logic stop,
                            input logic r_data, input logic r_stop);
    cycle(1'b0, r_data, 1'b1);
    for (int i = W - 1; i >= 0; i--) cycle(w[i], r_data, 1'b1);
    cycle(stop, r_stop, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int t1;
  int t2;

  initial begin
    din        = 1'b1;
    data_ready = 1'b0;
    reset      = 1'b0;

    // Reset held for two cycles with din toggling.
    cycle(1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    check("rst_data_out",   32'(data_out),   32'h0);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_overrun",    32'(overrun),    32'h0);
    cycle(1'b1, 1'b0, 1'b1);

    // Good frame 1011, consumer not ready.
    send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
    check("good_word",  32'(data_out),   32'hB);
    check("good_valid", 32'(data_valid), 32'h1);
    cycle(1'b1, 1'b0, 1'b1);
    check("good_hold",  32'(data_out),   32'hB);
    cycle(1'b1, 1'b1, 1'b1);
    check("good_drain", 32'(data_valid), 32'h0);

    // Frame error: 1100 with stop bit 0.
    send_frame(4'b1100, 1'b0, 1'b0, 1'b0);
    check("ferr_pulse", 32'(frame_err),  32'h1);
    check("ferr_valid", 32'(data_valid), 32'h0);
    cycle(1'b1, 1'b0, 1'b1);
    check("ferr_clear", 32'(frame_err),  32'h0);

    // Overrun: second back-to-back word dropped.
    send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b1, 1'b0, 1'b0);
    check("ovr_pulse", 32'(overrun),  32'h1);
    check("ovr_keep",  32'(data_out), 32'hB);
    cycle(1'b1, 1'b1, 1'b1);
    // Same, but the consumer drains during the second stop cycle.
    send_frame(4'b1011, 1'b1, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b1, 1'b0, 1'b1);
    check("noovr_pulse", 32'(overrun),    32'h0);
    check("noovr_word",  32'(data_out),   32'h6);
    check("noovr_valid", 32'(data_valid), 32'h1);
    cycle(1'b1, 1'b1, 1'b1);

    // Reset mid-frame, then a full frame 0110.
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 1'b0);
    check("midrst_busy", 32'(busy), 32'h0);
    send_frame(4'b0110, 1'b1, 1'b0, 1'b0);
    check("midrst_word",  32'(data_out),   32'h6);
    check("midrst_valid", 32'(data_valid), 32'h1);
    cycle(1'b1, 1'b1, 1'b1);

    // Back-to-back 1111 then 0001 with the consumer always ready.
    send_frame(4'b1111, 1'b1, 1'b1, 1'b1);
    t1 = cyc;
    check("b2b_word0", 32'(data_out), 32'hF);
    exp_q.push_back(4'b1111);
    exp_q.push_back(4'b0001);
    check("b2b_first", 32'(data_out), 32'(exp_q.pop_front()));
    send_frame(4'b0001, 1'b1, 1'b1, 1'b1);
    t2 = cyc;
    check("b2b_valid1", 32'(data_valid), 32'h1);
    check("b2b_second", 32'(data_out),   32'(exp_q.pop_front()));
    check("b2b_gap",    32'(t2 - t1),    32'd6);
    cycle(1'b1, 1'b1, 1'b1);
    check("b2b_drain",  32'(data_valid), 32'h0);

    // Randomized traffic: line mostly high, random ready, rare resets.
    for (int i = 0; i < 400; i++) begin
      cycle(logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 63) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/sipo_frame_ctrl.md
# sipo_frame_ctrl

Framed serial receive controller that sequences a WIDTH-bit serial-in/parallel-out shift register. It detects a start bit on the serial line and enables shifting for exactly WIDTH data cycles. It then checks the stop bit and hands the captured word to a downstream consumer over a valid/ready handshake. It sits between the raw serial input and any parallel-word consumer, replacing free-running SIPO capture with framed, flow-controlled capture.

## Interface
- `WIDTH`, 4, data bits per frame; legal range 2..32.
- `clk`  in  1  system clock; all logic is rising-edge.
- `reset`  in  1  synchronous, active-low reset; `reset==0` at a rising edge resets the block.
- `din`  in  1  serial line; idles high; one bit per clock.
- `data_ready`  in  1  consumer accepts `data_out` when `data_valid && data_ready`.
- `data_out`  out  WIDTH  last good word; first-received data bit is in the MSB.
- `data_valid`  out  1  `data_out` holds an unconsumed word.
- `busy`  out  1  a frame is in progress (state != IDLE).
- `frame_err`  out  1  one-cycle pulse: stop bit sampled as 0.
- `overrun`  out  1  one-cycle pulse: good frame dropped because the output was still full.

## Operation
- The FSM has three states:
  - IDLE: when `din==0`, go to DATA, clear the bit counter, and do not shift (the start bit is discarded).
  - DATA: each cycle, shift left with `din` into bit 0 and increment the counter. After the WIDTH-th shift, go to STOP.
  - STOP: sample `din` and always return to IDLE next cycle.
- Stop bit handling:
  - `din==1`: good frame.
  - `din==0`: pulse `frame_err`; the word is discarded and `data_out`/`data_valid` are unchanged.
- Good frame, output register:
  - If `!data_valid`, or `data_valid && data_ready` in the same cycle: load `data_out` and set `data_valid`.
  - Otherwise keep the old word, pulse `overrun`, and drop the new word.
- Handshake: `data_valid` clears on `data_valid && data_ready` unless a new word loads in that same cycle, in which case it stays 1 with the new data. `data_out` is stable while `data_valid && !data_ready`.
- The bit counter is `$clog2(WIDTH+1)` bits wide, counts 0..WIDTH, and never wraps in normal operation.
- Receiving continues while `data_valid` is held; the output register acts as a one-deep buffer.
- Reset values: state IDLE; shift register, counter, `data_out`, `data_valid`, `busy`, `frame_err` and `overrun` all 0.
- Reset mid-frame aborts the frame: no `data_valid`, no error pulses, and the partial word is lost.

## Timing
- Frame length is 1 + WIDTH + 1 cycles (start, data, stop).
- `data_valid`, `frame_err` and `overrun` assert on the edge that samples the stop bit, so they are visible the cycle after the stop bit is on `din`.
- Frames can run back to back: a start bit may sit on `din` in the cycle right after the stop bit, and IDLE detects it.
- `busy` rises the cycle after the start bit is sampled. It falls the cycle after the stop bit is sampled.
- A `din==0` held in IDLE after a frame error is treated as a new start bit; there is no break detection.
- `data_ready` has no combinational path to any output.

## Structure
- A shared package/header `sipo_frame_pkg` holds:
  - the state encodings `ST_IDLE=2'd0`, `ST_DATA=2'd1`, `ST_STOP=2'd2`;
  - the default WIDTH constant.
- Encoding `2'd3` is illegal and recovers to IDLE.
- Sub-module `sipo_shift_reg` (parameter WIDTH; ports `clk`, `reset`, `shift_en`, `din`, `q`):
  - shifts left only when `shift_en` is high;
  - uses the same synchronous active-low reset.
- The controller owns the FSM, the counter and the output buffer.

## Test plan
All scenarios use WIDTH=4.
- Reset: hold `reset=0` for 2 cycles with `din` toggling, then release -> all outputs 0 and `busy=0`.
- Good frame: `din` = 0,1,0,1,1,1 (start, 1011, stop) with `data_ready=0` -> `data_out=4'b1011` and `data_valid=1` the cycle after the stop bit, held stable; raise `data_ready` for 1 cycle -> `data_valid=0` next cycle.
- Frame error: `din` = 0,1,1,0,0,0 (start, 1100, bad stop 0) -> one-cycle `frame_err` pulse, `data_valid` stays 0.
- Overrun: a frame carrying 4'b1011 with `data_ready=0`, then a back-to-back frame carrying 4'b0110 -> `overrun` pulses, `data_out` stays 4'b1011. Repeat with `data_ready=1` in the second stop-sample cycle -> no `overrun`, `data_out=4'b0110`, `data_valid` stays 1.
- Reset mid-frame: `din` = 0,1,0 then `reset=0` for 1 cycle, then the full frame 0,0,1,1,0,1 -> exactly one word, 4'b0110, and no error pulses.
- Back-to-back frames 4'b1111 then 4'b0001 with `data_ready=1` throughout -> two `data_valid` cycles, 6 cycles apart, carrying the correct words in order.
